// File: rtl/pipeline_fetch_stage_pkg.sv
// Shared types and defaults for the MIPS32 instruction-fetch stage:
// FSM state encoding, IF/ID and skid entry layouts, reset defaults.
package pipeline_fetch_stage_pkg;

  localparam logic [31:0] NOP_DEFAULT      = 32'h0000_0000;
  localparam logic [29:0] RESET_PC_DEFAULT = 30'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [29:0] pc;
  } skid_entry_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [29:0] pc;
    logic        valid;
  } ifid_t;

  // Word-address increment; wraps modulo 2^30.
  function automatic logic [29:0] pc_inc(input logic [29:0] pc);
    return pc + 30'd1;
  endfunction

endpackage

// File: rtl/pipeline_if_skid.sv
// One-entry {instr, PC+1} buffer holding a fetched word while decode is stalled.
// Priority: clear > load > unload.
module pipeline_if_skid
  import pipeline_fetch_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [29:0] pc_i,
  output logic [31:0] instr_o,
  output logic [29:0] pc_o,
  output logic        full_o
);

  skid_entry_t entry_q, entry_d;
  logic        full_q, full_d;

  always_comb begin
    entry_d = entry_q;
    full_d  = full_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      entry_d.instr = instr_i;
      entry_d.pc    = pc_i;
      full_d        = 1'b1;
    end else if (unload_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q <= '0;
      full_q  <= 1'b0;
    end else begin
      entry_q <= entry_d;
      full_q  <= full_d;
    end
  end

  assign instr_o = entry_q.instr;
  assign pc_o    = entry_q.pc;
  assign full_o  = full_q;

endmodule

// File: rtl/pipeline_fetch_stage.sv
// Instruction-fetch stage: PC register, imem req/ack, skid buffer, IF/ID register.
// Optional IFETCH_PERF_EN adds fetch/bubble performance counters.
// Handshake: a word is taken on any edge where o_imem_req && i_imem_ack; o_imem_addr
// is registered and stays stable while o_imem_req is high without ack.
module pipeline_fetch_stage
  import pipeline_fetch_stage_pkg::*;
#(
  parameter logic [29:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP      = NOP_DEFAULT
`ifdef IFETCH_PERF_EN
  ,
  parameter int unsigned CNT_W    = 32
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [29:0] i_PC_target,
  input  logic        i_PCSrc,
  input  logic        i_stall,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_IFID_instr,
  output logic [29:0] o_IFID_PC,
  output logic        o_IFID_valid,
`ifdef IFETCH_PERF_EN
  output logic [CNT_W-1:0] o_fetch_cnt,
  output logic [CNT_W-1:0] o_bubble_cnt,
`endif
  output logic [1:0]  o_dbg_state
);

  fetch_state_e state_q, state_d;
  logic [29:0]  pc_q, pc_d, addr_q, addr_d;
  ifid_t        ifid_q, ifid_d;
  logic         ifid_load, req_w;
  logic         skid_load, skid_unload, skid_clear, skid_full;
  logic [31:0]  skid_instr;
  logic [29:0]  skid_pc, pc_next;

  assign pc_next = pc_inc(pc_q);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Next-state logic; a redirect while a request is unanswered must drain it in S_DROP.
  always_comb begin
    state_d = state_q;
    if (i_PCSrc) begin
      state_d = ((state_q != S_HOLD) && !i_imem_ack) ? S_DROP : S_FETCH;
    end else begin
      unique case (state_q)
        S_FETCH: if (i_imem_ack && i_stall) state_d = S_HOLD;
        S_HOLD:  if (!i_stall)              state_d = S_FETCH;
        S_DROP:  if (i_imem_ack)            state_d = S_FETCH;
        default:                            state_d = S_FETCH;
      endcase
    end
  end

  // Output / datapath control decode
  always_comb begin
    req_w        = (state_q != S_HOLD);
    pc_d         = pc_q;
    ifid_d       = ifid_q;
    ifid_load    = 1'b0;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_clear   = 1'b0;
    if (i_PCSrc) begin
      pc_d         = i_PC_target;
      skid_clear   = 1'b1;
      ifid_load    = 1'b1;
      ifid_d.instr = NOP;
      ifid_d.pc    = '0;
      ifid_d.valid = 1'b0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (i_imem_ack) begin
            pc_d = pc_next;
            if (i_stall) begin
              skid_load = 1'b1;
            end else begin
              ifid_load    = 1'b1;
              ifid_d.instr = i_imem_rdata;
              ifid_d.pc    = pc_next;
              ifid_d.valid = 1'b1;
            end
          end else if (!i_stall) begin
            ifid_load    = 1'b1;
            ifid_d.instr = NOP;
            ifid_d.pc    = '0;
            ifid_d.valid = 1'b0;
          end
        end
        S_HOLD: begin
          if (!i_stall) begin
            skid_unload  = 1'b1;
            ifid_load    = 1'b1;
            ifid_d.instr = skid_instr;
            ifid_d.pc    = skid_pc;
            ifid_d.valid = skid_full;
          end
        end
        default: begin
          if (!i_stall) begin
            ifid_load    = 1'b1;
            ifid_d.instr = NOP;
            ifid_d.pc    = '0;
            ifid_d.valid = 1'b0;
          end
        end
      endcase
    end
  end

  // While draining a stale request the address must not move; otherwise it follows pc.
  assign addr_d = (state_d == S_DROP) ? addr_q : pc_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q   <= RESET_PC;
      addr_q <= RESET_PC;
      ifid_q <= '{instr: NOP, pc: '0, valid: 1'b0};
    end else begin
      pc_q   <= pc_d;
      addr_q <= addr_d;
      if (ifid_load) ifid_q <= ifid_d;
    end
  end

  pipeline_if_skid u_skid (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .instr_i  (i_imem_rdata),
    .pc_i     (pc_next),
    .instr_o  (skid_instr),
    .pc_o     (skid_pc),
    .full_o   (skid_full)
  );

`ifdef IFETCH_PERF_EN
  logic [CNT_W-1:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (ifid_load) begin
      if (ifid_d.valid) fetch_cnt_q  <= fetch_cnt_q + 1'b1;
      else              bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign o_fetch_cnt  = fetch_cnt_q;
  assign o_bubble_cnt = bubble_cnt_q;
`endif

  assign o_imem_req   = req_w & i_rst_n;
  assign o_imem_addr  = {addr_q, 2'b00};
  assign o_IFID_instr = ifid_q.instr;
  assign o_IFID_PC    = ifid_q.pc;
  assign o_IFID_valid = ifid_q.valid;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_pipeline_fetch_stage.sv
// Directed bench for pipeline_fetch_stage with a behavioural imem responder
// whose ack latency is set per scenario.
module tb_pipeline_fetch_stage;
  import pipeline_fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] pc_target;
  logic        pcsrc, stall;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] ifid_instr;
  logic [29:0] ifid_pc;
  logic        ifid_valid;
  logic [1:0]  dbg_state;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  logic [31:0] exp_q[$];

  pipeline_fetch_stage dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_PC_target  (pc_target),
    .i_PCSrc      (pcsrc),
    .i_stall      (stall),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_ack   (imem_ack),
    .i_imem_rdata (imem_rdata),
    .o_IFID_instr (ifid_instr),
    .o_IFID_PC    (ifid_pc),
    .o_IFID_valid (ifid_valid),
`ifdef IFETCH_PERF_EN
    .o_fetch_cnt  (fetch_cnt),
    .o_bubble_cnt (bubble_cnt),
`endif
    .o_dbg_state  (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {2'b11, a};
  endfunction

  // imem responder: acks after ack_delay waiting cycles on each request
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      imem_rdata = mem_word(imem_addr[31:2]);
      if (imem_req) begin
        if (wait_cnt >= ack_delay) begin
          imem_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          imem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Driver: reset released away from both clock edges
  task automatic do_reset(input int delay);
    rst_n     = 1'b0;
    pcsrc     = 1'b0;
    stall     = 1'b0;
    pc_target = '0;
    ack_delay = delay;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; pcsrc = 1'b0; stall = 1'b0; pc_target = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
    checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", ifid_valid); end
    checks++; if (ifid_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%0h exp=0", ifid_instr); end
    checks++; if (ifid_pc !== 30'h0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", ifid_pc); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", imem_addr); end
    checks++; if (dbg_state !== S_FETCH) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_FETCH); end
  endtask

  task automatic test_back_to_back();
    do_reset(0);
    for (int i = 0; i < 8; i++) exp_q.push_back(mem_word(30'(i)));
    for (int i = 1; i <= 8; i++) begin
      logic [31:0] e;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 30'(i)) begin failures++; $display("FAIL b2b_pc got=%0h/%0b exp=%0h/1", ifid_pc, ifid_valid, i); end
      checks++; if (ifid_instr !== e) begin failures++; $display("FAIL b2b_instr got=%0h exp=%0h", ifid_instr, e); end
`ifdef IFETCH_PERF_EN
      checks++; if (fetch_cnt !== 32'(i)) begin failures++; $display("FAIL b2b_fetch_cnt got=%0d exp=%0d", fetch_cnt, i); end
`endif
    end
  endtask

  task automatic test_wait_states();
    do_reset(3);
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < 3; b++) begin
        @(posedge clk); #1;
        checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin failures++; $display("FAIL wait_bubble got=%0b/%0h exp=0/0", ifid_valid, ifid_instr); end
        checks++; if (imem_addr !== 32'(k * 4)) begin failures++; $display("FAIL wait_addr got=%0h exp=%0h", imem_addr, k * 4); end
      end
      @(posedge clk); #1;
      checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 30'(k + 1) || ifid_instr !== mem_word(30'(k))) begin
        failures++; $display("FAIL wait_instr got=%0b/%0h/%0h exp=1/%0h/%0h", ifid_valid, ifid_pc, ifid_instr, k + 1, mem_word(30'(k)));
      end
    end
`ifdef IFETCH_PERF_EN
    checks++; if (fetch_cnt !== 32'd2 || bubble_cnt !== 32'd6) begin failures++; $display("FAIL wait_cnts got=%0d/%0d exp=2/6", fetch_cnt, bubble_cnt); end
`endif
  endtask

  task automatic test_stall_hold();
    do_reset(0);
    repeat (16) @(posedge clk);
    #1;
    checks++; if (ifid_pc !== 30'h10) begin failures++; $display("FAIL stall_pre_pc got=%0h exp=10", ifid_pc); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); stall = 1'b1;
      @(posedge clk); #1;
      checks++; if (dbg_state !== S_HOLD || imem_req !== 1'b0) begin failures++; $display("FAIL stall_hold got=%0d/%0b exp=%0d/0", dbg_state, imem_req, S_HOLD); end
      checks++; if (ifid_pc !== 30'h10 || ifid_instr !== mem_word(30'hF)) begin failures++; $display("FAIL stall_ifid_held got=%0h/%0h exp=10/%0h", ifid_pc, ifid_instr, mem_word(30'hF)); end
    end
    @(negedge clk); stall = 1'b0;
    @(posedge clk); #1;
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 30'h11 || ifid_instr !== mem_word(30'h10)) begin
      failures++; $display("FAIL stall_release got=%0b/%0h/%0h exp=1/11/%0h", ifid_valid, ifid_pc, ifid_instr, mem_word(30'h10));
    end
    checks++; if (imem_addr !== 32'h44) begin failures++; $display("FAIL stall_next_addr got=%0h exp=44", imem_addr); end
    @(posedge clk); #1;
    checks++; if (ifid_pc !== 30'h12 || ifid_instr !== mem_word(30'h11)) begin failures++; $display("FAIL stall_after got=%0h/%0h exp=12/%0h", ifid_pc, ifid_instr, mem_word(30'h11)); end
  endtask

  task automatic test_redirect_drop();
    do_reset(0);
    repeat (64) @(posedge clk);
    #1;
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL drop_pre_addr got=%0h exp=100", imem_addr); end
    ack_delay = 3;
    @(negedge clk); pcsrc = 1'b1; pc_target = 30'h200;
    @(posedge clk); #1;
    checks++; if (dbg_state !== S_DROP || imem_req !== 1'b1) begin failures++; $display("FAIL drop_enter got=%0d/%0b exp=%0d/1", dbg_state, imem_req, S_DROP); end
    @(negedge clk); pcsrc = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      @(posedge clk); #1;
      checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL drop_no_stale got=%0b exp=0", ifid_valid); end
      if (c < 2) begin
        checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL drop_addr_stable got=%0h exp=100", imem_addr); end
      end
    end
    checks++; if (dbg_state !== S_FETCH || imem_addr !== 32'h800) begin failures++; $display("FAIL drop_exit got=%0d/%0h exp=%0d/800", dbg_state, imem_addr, S_FETCH); end
    ack_delay = 0;
    @(posedge clk); #1;
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 30'h201 || ifid_instr !== mem_word(30'h200)) begin
      failures++; $display("FAIL drop_target got=%0b/%0h/%0h exp=1/201/%0h", ifid_valid, ifid_pc, ifid_instr, mem_word(30'h200));
    end
  endtask

  task automatic test_redirect_stall();
    do_reset(0);
    repeat (4) @(posedge clk);
    @(negedge clk); stall = 1'b1;
    @(posedge clk); #1;
    checks++; if (dbg_state !== S_HOLD || ifid_pc !== 30'h4) begin failures++; $display("FAIL rs_hold got=%0d/%0h exp=%0d/4", dbg_state, ifid_pc, S_HOLD); end
    @(negedge clk); pcsrc = 1'b1; pc_target = 30'h80;
    @(posedge clk); #1;
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin failures++; $display("FAIL rs_flush got=%0b/%0h exp=0/0", ifid_valid, ifid_instr); end
    checks++; if (dbg_state !== S_FETCH || imem_addr !== 32'h200) begin failures++; $display("FAIL rs_state got=%0d/%0h exp=%0d/200", dbg_state, imem_addr, S_FETCH); end
    @(negedge clk); pcsrc = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 30'h81 || ifid_instr !== mem_word(30'h80)) begin
      failures++; $display("FAIL rs_skid_cleared got=%0b/%0h/%0h exp=1/81/%0h", ifid_valid, ifid_pc, ifid_instr, mem_word(30'h80));
    end
  endtask

  task automatic test_wrap_and_async_reset();
    do_reset(0);
    @(negedge clk); pcsrc = 1'b1; pc_target = 30'h3FFF_FFFF;
    @(posedge clk); #1;
    checks++; if (ifid_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_redirect got=%0b/%0h exp=0/fffffffc", ifid_valid, imem_addr); end
    @(negedge clk); pcsrc = 1'b0;
    @(posedge clk); #1;
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 30'h0 || ifid_instr !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL wrap_ifid got=%0b/%0h/%0h exp=1/0/ffffffff", ifid_valid, ifid_pc, ifid_instr);
    end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%0h exp=0", imem_addr); end
    @(posedge clk); #1;
    checks++; if (ifid_pc !== 30'h1 || ifid_instr !== mem_word(30'h0)) begin failures++; $display("FAIL wrap_next got=%0h/%0h exp=1/%0h", ifid_pc, ifid_instr, mem_word(30'h0)); end
    ack_delay = 3;
    @(posedge clk); #1;
    checks++; if (ifid_valid !== 1'b0 || imem_addr !== 32'h4) begin failures++; $display("FAIL arst_prewait got=%0b/%0h exp=0/4", ifid_valid, imem_addr); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin failures++; $display("FAIL arst_req_addr got=%0b/%0h exp=0/0", imem_req, imem_addr); end
    checks++; if (ifid_pc !== 30'h0 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin failures++; $display("FAIL arst_ifid got=%0h/%0b/%0h exp=0/0/0", ifid_pc, ifid_valid, ifid_instr); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_stall_hold();
    test_redirect_drop();
    test_redirect_stall();
    test_wrap_and_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
